// File: rtl/disp_frame_sched.sv
// Chooses which 3-digit frame (keypad entry or calculator result) drives the scanned display.
// Results are held for HOLD_CYC cycles, error results blink, and a key press cancels a shown result.
module disp_frame_sched #(
    parameter int FRAME_W   = 24,
    parameter int CNT_W     = 26,
    parameter int HOLD_CYC  = 25000000,
    parameter int BLINK_CYC = 6250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_req,
    input  logic [FRAME_W-1:0] in_frame,
    output logic               in_ack,
    input  logic               res_req,
    input  logic [FRAME_W-1:0] res_frame,
    input  logic               res_err,
    output logic               res_ack,
    output logic [FRAME_W-1:0] seg,
    output logic [1:0]         owner
);

    // Handshake: a requester raises X_req with its frame and holds both until X_ack;
    // a request is accepted in any cycle where X_req=1 and X_ack=0, and X_ack pulses the next cycle.
    typedef enum logic {ST_ENTRY, ST_RESULT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLD_CYC == 0) ? '0 : CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] entry_buf_q, entry_buf_d;
    logic [FRAME_W-1:0] res_buf_q, res_buf_d;
    logic               err_q, err_d;
    logic               blank_q, blank_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               in_ack_q, res_ack_q;
    logic [FRAME_W-1:0] seg_q, seg_d;
    logic [1:0]         owner_q, owner_d;
    logic               res_acc, in_acc;

    assign res_acc = res_req && !res_ack_q;
    assign in_acc  = in_req && !in_ack_q && !res_acc;

    always_comb begin
        state_d     = state_q;
        entry_buf_d = entry_buf_q;
        res_buf_d   = res_buf_q;
        err_d       = err_q;
        blank_d     = blank_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;

        if (in_acc) begin
            entry_buf_d = in_frame;
        end

        if (res_acc) begin
            state_d     = ST_RESULT;
            res_buf_d   = res_frame;
            err_d       = res_err;
            blank_d     = 1'b0;
            hold_cnt_d  = HOLD_LOAD;
            blink_cnt_d = '0;
        end else if (state_q == ST_RESULT) begin
            if (in_acc) begin
                state_d = ST_ENTRY;
            end else if (HOLD_CYC != 0 && hold_cnt_q == '0) begin
                state_d = ST_ENTRY;
            end else begin
                // HOLD_CYC == 0 leaves the counter parked at 0 with no timeout.
                if (HOLD_CYC != 0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
                if (err_q) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blank_d     = !blank_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
        end

        if (state_d == ST_ENTRY) begin
            seg_d   = entry_buf_d;
            owner_d = 2'd1;
        end else begin
            seg_d   = (err_d && blank_d) ? '0 : res_buf_d;
            owner_d = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTRY;
            entry_buf_q <= '0;
            res_buf_q   <= '0;
            err_q       <= 1'b0;
            blank_q     <= 1'b0;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            in_ack_q    <= 1'b0;
            res_ack_q   <= 1'b0;
            seg_q       <= '0;
            owner_q     <= 2'd1;
        end else begin
            state_q     <= state_d;
            entry_buf_q <= entry_buf_d;
            res_buf_q   <= res_buf_d;
            err_q       <= err_d;
            blank_q     <= blank_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            in_ack_q    <= in_acc;
            res_ack_q   <= res_acc;
            seg_q       <= seg_d;
            owner_q     <= owner_d;
        end
    end

    assign in_ack  = in_ack_q;
    assign res_ack = res_ack_q;
    assign seg     = seg_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_disp_frame_sched.sv
// Directed bench for disp_frame_sched with HOLD_CYC=8, BLINK_CYC=2.
// Inputs change and outputs are checked on the falling edge; the DUT updates on the rising edge.
module tb_disp_frame_sched;

  localparam int FRAME_W = 24;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_req = 1'b0;
  logic [FRAME_W-1:0] in_frame = '0;
  logic               in_ack;
  logic               res_req = 1'b0;
  logic [FRAME_W-1:0] res_frame = '0;
  logic               res_err = 1'b0;
  logic               res_ack;
  logic [FRAME_W-1:0] seg;
  logic [1:0]         owner;

  int n_cmp = 0;
  int n_bad = 0;

  disp_frame_sched #(
    .FRAME_W(24), .CNT_W(26), .HOLD_CYC(8), .BLINK_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_frame(in_frame), .in_ack(in_ack),
    .res_req(res_req), .res_frame(res_frame), .res_err(res_err), .res_ack(res_ack),
    .seg(seg), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== 24'h0 || owner !== 2'd1 || in_ack !== 1'b0 || res_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d: seg=%h owner=%0d in_ack=%b res_ack=%b, want seg=000000 owner=1 acks=0",
                 i, seg, owner, in_ack, res_ack);
      end
    end
  endtask

  task automatic test_entry();
    int acks;
    in_req = 1'b1; in_frame = 24'h3F065B;
    @(negedge clk);
    n_cmp++;
    if (in_ack !== 1'b1 || seg !== 24'h3F065B || owner !== 2'd1) begin
      n_bad++;
      $display("FAIL entry_accept: in_ack=%b seg=%h owner=%0d, want 1 3f065b 1", in_ack, seg, owner);
    end
    acks = 1;
    // Request deliberately left high during the ack cycle; it must not be accepted twice.
    @(negedge clk);
    in_req = 1'b0; in_frame = 24'h0;
    if (in_ack === 1'b1) acks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks !== 1) begin
      n_bad++;
      $display("FAIL entry_single_ack: acks=%0d, want 1", acks);
    end
    n_cmp++;
    if (seg !== 24'h3F065B || owner !== 2'd1) begin
      n_bad++;
      $display("FAIL entry_hold: seg=%h owner=%0d, want 3f065b 1", seg, owner);
    end
  endtask

  task automatic test_result();
    res_req = 1'b1; res_frame = 24'h4F6666; res_err = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_ack !== 1'b1 || in_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL result_ack: res_ack=%b in_ack=%b, want 1 0", res_ack, in_ack);
    end
    res_req = 1'b0; res_frame = 24'h0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      n_cmp++;
      if (owner !== 2'd2 || seg !== 24'h4F6666 || (i > 1 && res_ack !== 1'b0)) begin
        n_bad++;
        $display("FAIL result_hold cyc=%0d: owner=%0d seg=%h res_ack=%b, want 2 4f6666", i, owner, seg, res_ack);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (owner !== 2'd1 || seg !== 24'h3F065B) begin
      n_bad++;
      $display("FAIL result_timeout: owner=%0d seg=%h, want 1 3f065b", owner, seg);
    end
  endtask

  task automatic test_priority();
    in_req = 1'b1; in_frame = 24'h065B4F;
    res_req = 1'b1; res_frame = 24'h66666D; res_err = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_ack !== 1'b1 || in_ack !== 1'b0 || owner !== 2'd2 || seg !== 24'h66666D) begin
      n_bad++;
      $display("FAIL prio_result_first: res_ack=%b in_ack=%b owner=%0d seg=%h, want 1 0 2 66666d",
               res_ack, in_ack, owner, seg);
    end
    res_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ack !== 1'b1 || res_ack !== 1'b0 || owner !== 2'd1 || seg !== 24'h065B4F) begin
      n_bad++;
      $display("FAIL prio_entry_next: in_ack=%b res_ack=%b owner=%0d seg=%h, want 1 0 1 065b4f",
               in_ack, res_ack, owner, seg);
    end
    in_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ack !== 1'b0 || owner !== 2'd1 || seg !== 24'h065B4F) begin
      n_bad++;
      $display("FAIL prio_settle: in_ack=%b owner=%0d seg=%h, want 0 1 065b4f", in_ack, owner, seg);
    end
  endtask

  task automatic test_blink();
    logic [FRAME_W-1:0] exp_seg [8];
    exp_seg = '{24'h797979, 24'h797979, 24'h0, 24'h0, 24'h797979, 24'h797979, 24'h0, 24'h0};
    res_req = 1'b1; res_frame = 24'h797979; res_err = 1'b1;
    @(negedge clk);
    res_req = 1'b0; res_err = 1'b0; res_frame = 24'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (owner !== 2'd2 || seg !== exp_seg[i]) begin
        n_bad++;
        $display("FAIL blink cyc=%0d: owner=%0d seg=%h, want 2 %h", i + 1, owner, seg, exp_seg[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (owner !== 2'd1 || seg !== 24'h065B4F) begin
      n_bad++;
      $display("FAIL blink_timeout: owner=%0d seg=%h, want 1 065b4f", owner, seg);
    end
  endtask

  task automatic test_reset_mid();
    res_req = 1'b1; res_frame = 24'h797979; res_err = 1'b1;
    @(negedge clk);
    res_req = 1'b0; res_err = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (owner !== 2'd2 || seg !== 24'h0) begin
      n_bad++;
      $display("FAIL mid_blanked: owner=%0d seg=%h, want 2 000000", owner, seg);
    end
    rst = 1'b1;
    res_req = 1'b1; res_frame = 24'h5B5B5B; res_err = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg !== 24'h0 || owner !== 2'd1 || res_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: seg=%h owner=%0d res_ack=%b, want 000000 1 0", seg, owner, res_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (res_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_noack: res_ack=%b, want 0", res_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_ack !== 1'b1 || owner !== 2'd2 || seg !== 24'h5B5B5B) begin
      n_bad++;
      $display("FAIL mid_reack: res_ack=%b owner=%0d seg=%h, want 1 2 5b5b5b", res_ack, owner, seg);
    end
    res_req = 1'b0;
    repeat (8) @(negedge clk);
    // entry_buf was cleared by reset, so the display reverts to a blank entry frame.
    n_cmp++;
    if (owner !== 2'd1 || seg !== 24'h0) begin
      n_bad++;
      $display("FAIL mid_revert: owner=%0d seg=%h, want 1 000000", owner, seg);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_result();
    test_priority();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
